// File: rtl/alu_pkg.sv
// Shared ALU definitions: Boolean function codes and the legality check used
// wherever a bfn field has to be validated.
package alu_pkg;

  localparam logic [3:0] BFN_AND  = 4'b1000;
  localparam logic [3:0] BFN_OR   = 4'b1110;
  localparam logic [3:0] BFN_XOR  = 4'b0110;
  localparam logic [3:0] BFN_BUFF = 4'b1010;

  localparam int unsigned OP_COUNT_W = 16;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

  function automatic logic bfn_is_legal(input logic [3:0] bfn);
    return (bfn == BFN_AND) || (bfn == BFN_OR) ||
           (bfn == BFN_XOR) || (bfn == BFN_BUFF);
  endfunction

endpackage

// File: rtl/bool_arbiter_fu.sv
// Bitwise Boolean function unit: every result bit is a 2-input LUT lookup of
// the function code, indexed by {b, a} of that bit position.
module bool_arbiter_fu #(
  parameter int DW = 32
) (
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  input  logic [3:0]    bfn_i,
  output logic [DW-1:0] y_o
);

  // With {b,a} as the index, the legal codes decode to AND/OR/XOR/pass-A.
  for (genvar gi = 0; gi < DW; gi++) begin : g_bit
    assign y_o[gi] = bfn_i[{b_i[gi], a_i[gi]}];
  end

endmodule

// File: rtl/bool_arbiter.sv
// Two-port arbiter in front of a shared Boolean function unit, with a
// one-entry registered result buffer and valid/ready backpressure.
module bool_arbiter
  import alu_pkg::*;
#(
  parameter int DW         = 32,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DW-1:0]         req0_a,
  input  logic [DW-1:0]         req0_b,
  input  logic [3:0]            req0_bfn,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DW-1:0]         req1_a,
  input  logic [DW-1:0]         req1_b,
  input  logic [3:0]            req1_bfn,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DW-1:0]         rsp_data,
  output logic                  rsp_src,
  output logic                  rsp_err,
  output logic [OP_COUNT_W-1:0] op_count
);

  buf_state_e            state_q, state_d;
  logic [DW-1:0]         data_q, data_d;
  logic                  src_q, src_d;
  logic                  err_q, err_d;
  logic [OP_COUNT_W-1:0] count_q, count_d;
  logic                  last_grant_q, last_grant_d;

  logic          grant;
  logic          any_valid;
  logic          can_accept;
  logic          accept;
  logic [DW-1:0] op_a, op_b, fu_y;
  logic [3:0]    op_bfn;
  logic          op_legal;

  // A lone requester always wins; the pointer only breaks ties.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = FIXED_PRIO ? 1'b0 : ~last_grant_q;
    end else begin
      grant = ~req0_valid;
    end
  end

  assign any_valid  = req0_valid | req1_valid;
  assign can_accept = (state_q == BUF_EMPTY) | rsp_ready;
  assign accept     = can_accept & any_valid;
  assign req0_ready = accept & ~grant;
  assign req1_ready = accept & grant;

  assign op_a   = grant ? req1_a   : req0_a;
  assign op_b   = grant ? req1_b   : req0_b;
  assign op_bfn = grant ? req1_bfn : req0_bfn;

  bool_arbiter_fu #(
    .DW(DW)
  ) u_fu (
    .a_i  (op_a),
    .b_i  (op_b),
    .bfn_i(op_bfn),
    .y_o  (fu_y)
  );

  assign op_legal = bfn_is_legal(op_bfn);

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    src_d        = src_q;
    err_d        = err_q;
    count_d      = count_q;
    last_grant_d = last_grant_q;

    if (accept) begin
      // Illegal codes still consume a slot; only the data is forced to zero.
      state_d      = BUF_FULL;
      data_d       = op_legal ? fu_y : '0;
      src_d        = grant;
      err_d        = ~op_legal;
      count_d      = count_q + 1'b1;
      last_grant_d = grant;
    end else if (state_q == BUF_FULL && rsp_ready) begin
      state_d = BUF_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= BUF_EMPTY;
      data_q       <= '0;
      src_q        <= 1'b0;
      err_q        <= 1'b0;
      count_q      <= '0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      src_q        <= src_d;
      err_q        <= err_d;
      count_q      <= count_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign rsp_valid = (state_q == BUF_FULL);
  assign rsp_data  = data_q;
  assign rsp_src   = src_q;
  assign rsp_err   = err_q;
  assign op_count  = count_q;

endmodule
